// File: rtl/psum_accumulator.sv
// Row partial-sum accumulator: sums NUM_PASSES aligned passes per point into a local
// buffer, then drains the saturated row over a valid/ready handshake.
module psum_accumulator #(
    parameter int I_WIDTH    = 8,
    parameter int F_WIDTH    = 8,
    parameter int GUARD      = 4,
    parameter int DEPTH      = 16,
    parameter int MAX_PASSES = 16,
    parameter int PTS_WIDTH  = $clog2(DEPTH + 1),
    parameter int PASS_WIDTH = $clog2(MAX_PASSES + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                start_i,
    input  logic [PASS_WIDTH-1:0]               num_passes_i,
    input  logic [PTS_WIDTH-1:0]                num_points_i,
    input  logic signed [I_WIDTH+F_WIDTH-1:0]   in_data_i,
    input  logic                                in_valid_i,
    output logic signed [I_WIDTH+F_WIDTH-1:0]   out_data_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                sat_o
);

    localparam int W     = I_WIDTH + F_WIDTH;
    localparam int ACC_W = W + GUARD;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic signed [ACC_W-1:0]  r_buf [DEPTH];
    logic [PASS_WIDTH-1:0]    r_npass;
    logic [PTS_WIDTH-1:0]     r_npts;
    logic [PASS_WIDTH-1:0]    r_pass;
    logic [IDX_W-1:0]         r_pt;
    logic [IDX_W-1:0]         r_rd;
    logic signed [W-1:0]      r_out_data;
    logic                     r_out_valid;
    logic                     r_done;
    logic                     r_sat;

    logic                     w_start_ok;
    logic                     w_in_fire;
    logic                     w_last_pt;
    logic                     w_last_pass;
    logic                     w_accum_done;
    logic                     w_out_fire;
    logic                     w_rd_last;
    logic                     w_drain_done;
    logic [IDX_W-1:0]         w_pt_nxt;
    logic [IDX_W-1:0]         w_rd_nxt;
    logic signed [ACC_W-1:0]  w_in_ext;
    logic signed [ACC_W-1:0]  w_acc_new;
    logic signed [ACC_W-1:0]  w_pres_acc;
    logic [GUARD:0]           w_hi;
    logic                     w_ovf;
    logic signed [W-1:0]      w_sat_val;

    assign w_start_ok   = start_i && (num_passes_i != '0) && (num_points_i != '0);
    assign w_in_fire    = (r_state == S_ACCUM) && in_valid_i;
    assign w_last_pt    = (PTS_WIDTH'(r_pt) == (r_npts - PTS_WIDTH'(1)));
    assign w_last_pass  = (r_pass == (r_npass - PASS_WIDTH'(1)));
    assign w_accum_done = w_in_fire && w_last_pt && w_last_pass;
    assign w_out_fire   = (r_state == S_DRAIN) && r_out_valid && out_ready_i;
    assign w_rd_last    = (PTS_WIDTH'(r_rd) == (r_npts - PTS_WIDTH'(1)));
    assign w_drain_done = w_out_fire && w_rd_last;
    assign w_pt_nxt     = r_pt + IDX_W'(1);
    assign w_rd_nxt     = r_rd + IDX_W'(1);

    assign w_in_ext  = {{GUARD{in_data_i[W-1]}}, in_data_i};
    assign w_acc_new = (r_pass == '0) ? w_in_ext : (r_buf[r_pt] + w_in_ext);

    // Entry 0 may be written on the same edge it is first presented; bypass the buffer then.
    assign w_pres_acc = (r_state == S_ACCUM)
                      ? ((r_pt == '0) ? w_acc_new : r_buf[0])
                      : r_buf[w_rd_nxt];

    assign w_hi      = w_pres_acc[ACC_W-1:W-1];
    assign w_ovf     = !((&w_hi) || (~|w_hi));
    assign w_sat_val = !w_ovf ? w_pres_acc[W-1:0]
                     : (w_pres_acc[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok)   w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_accum_done) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (r_state != S_IDLE);
        out_data_o  = r_out_data;
        out_valid_o = r_out_valid;
        done_o      = r_done;
        sat_o       = r_sat;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_npass     <= '0;
            r_npts      <= '0;
            r_pass      <= '0;
            r_pt        <= '0;
            r_rd        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_done <= w_drain_done;
            if ((r_state == S_IDLE) && w_start_ok) begin
                r_npass <= num_passes_i;
                r_npts  <= num_points_i;
                r_pass  <= '0;
                r_pt    <= '0;
                r_sat   <= 1'b0;
            end
            if (w_in_fire) begin
                if (w_last_pt) begin
                    r_pt   <= '0;
                    r_pass <= r_pass + PASS_WIDTH'(1);
                end else begin
                    r_pt <= w_pt_nxt;
                end
            end
            if (w_accum_done) begin
                r_rd        <= '0;
                r_out_valid <= 1'b1;
                r_out_data  <= w_sat_val;
                r_sat       <= r_sat | w_ovf;
            end
            if (w_out_fire) begin
                if (w_rd_last) begin
                    r_out_valid <= 1'b0;
                end else begin
                    r_rd       <= w_rd_nxt;
                    r_out_data <= w_sat_val;
                    r_sat      <= r_sat | w_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_in_fire) r_buf[r_pt] <= w_acc_new;
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator (W=16): accumulation, saturation, backpressure,
// mid-row reset and ignored stimulus, each checked against hand-computed values.
module tb_psum_accumulator;

    logic               clk_i = 1'b0;
    logic               rst_n_i = 1'b0;
    logic               start_i = 1'b0;
    logic [4:0]         num_passes_i = '0;
    logic [4:0]         num_points_i = '0;
    logic signed [15:0] in_data_i = '0;
    logic               in_valid_i = 1'b0;
    logic signed [15:0] out_data_o;
    logic               out_valid_o;
    logic               out_ready_i = 1'b0;
    logic               busy_o;
    logic               done_o;
    logic               sat_o;

    int checks = 0;
    int errors = 0;

    psum_accumulator #(
        .I_WIDTH(8), .F_WIDTH(8), .GUARD(4), .DEPTH(16), .MAX_PASSES(16)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
        .num_passes_i(num_passes_i), .num_points_i(num_points_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [4:0] p, input logic [4:0] n);
        start_i = 1'b1; num_passes_i = p; num_points_i = n;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid_i = 1'b1; in_data_i = d;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        tick(); tick();
        checks++;
        if ({out_valid_o, done_o, busy_o, sat_o} !== 4'b0000 || out_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset got v%b d%b b%b s%b data %h exp all 0", out_valid_o, done_o, busy_o, sat_o, out_data_o);
        end
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready_i = 1'b0;
        do_start(5'd3, 5'd2);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy_o); end
        for (int p = 0; p < 3; p++) begin
            send(16'h0100);
            send(16'h0200);
        end
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'h0300) begin
            errors++; $display("FAIL basic_out0 got v%b %h exp v1 0300", out_valid_o, out_data_o);
        end
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'h0600 || done_o !== 1'b0) begin
            errors++; $display("FAIL basic_out1 got v%b %h d%b exp v1 0600 d0", out_valid_o, out_data_o, done_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || sat_o !== 1'b0) begin
            errors++; $display("FAIL basic_done got d%b v%b b%b s%b exp d1 v0 b0 s0", done_o, out_valid_o, busy_o, sat_o);
        end
        out_ready_i = 1'b0;
        tick();
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done_o); end
    endtask

    task automatic test_saturation();
        do_start(5'd2, 5'd1);
        send(16'h7000);
        send(16'h7000);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'h7FFF || sat_o !== 1'b1) begin
            errors++; $display("FAIL sat_pos got v%b %h s%b exp v1 7fff s1", out_valid_o, out_data_o, sat_o);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || sat_o !== 1'b1) begin
            errors++; $display("FAIL sat_pos_done got d%b s%b exp d1 s1", done_o, sat_o);
        end
        do_start(5'd2, 5'd1);
        checks++;
        if (sat_o !== 1'b0) begin errors++; $display("FAIL sat_clear got %b exp 0", sat_o); end
        send(16'h9000);
        send(16'h9000);
        checks++;
        if (out_data_o !== 16'h8000 || sat_o !== 1'b1) begin
            errors++; $display("FAIL sat_neg got %h s%b exp 8000 s1", out_data_o, sat_o);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        do_start(5'd2, 5'd1);
        send(16'hFF00);
        send(16'h0080);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'hFF80 || sat_o !== 1'b0) begin
            errors++; $display("FAIL neg_small got v%b %h s%b exp v1 ff80 s0", out_valid_o, out_data_o, sat_o);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL neg_small_done got %b exp 1", done_o); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q [4];
        exp_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        do_start(5'd1, 5'd4);
        for (int i = 0; i < 4; i++) send(exp_q[i]);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 16'h0011) begin
                errors++; $display("FAIL bp_hold%0d got v%b %h exp v1 0011", i, out_valid_o, out_data_o);
            end
            tick();
        end
        out_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== exp_q[i]) begin
                errors++; $display("FAIL b2b_out%0d got v%b %h exp v1 %h", i, out_valid_o, out_data_o, exp_q[i]);
            end
        end
        tick();
        out_ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_done got d%b v%b exp d1 v0", done_o, out_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        do_start(5'd3, 5'd2);
        send(16'h0100);
        send(16'h0200);
        send(16'h0100);
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({out_valid_o, done_o, busy_o, sat_o} !== 4'b0000 || out_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid got v%b d%b b%b s%b %h exp all 0", out_valid_o, done_o, busy_o, sat_o, out_data_o);
        end
        tick();
        rst_n_i = 1'b1;
        tick();
        do_start(5'd1, 5'd2);
        send(16'h0005);
        send(16'h0006);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'h0005) begin
            errors++; $display("FAIL reset_new0 got v%b %h exp v1 0005", out_valid_o, out_data_o);
        end
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (out_data_o !== 16'h0006) begin errors++; $display("FAIL reset_new1 got %h exp 0006", out_data_o); end
        tick();
        out_ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL reset_new_done got %b exp 1", done_o); end
    endtask

    task automatic test_ignored();
        do_start(5'd1, 5'd2);
        send(16'h0001);
        send(16'h0002);
        start_i = 1'b1; num_passes_i = 5'd1; num_points_i = 5'd1;
        in_valid_i = 1'b1; in_data_i = 16'h7FFF;
        tick();
        start_i = 1'b0; in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'h0001 || busy_o !== 1'b1) begin
            errors++; $display("FAIL ign_drain got v%b %h b%b exp v1 0001 b1", out_valid_o, out_data_o, busy_o);
        end
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (out_data_o !== 16'h0002) begin errors++; $display("FAIL ign_drain1 got %h exp 0002", out_data_o); end
        tick();
        out_ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL ign_done got d%b b%b exp d1 b0", done_o, busy_o);
        end
        do_start(5'd2, 5'd0);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL ign_pts0 got busy %b exp 0", busy_o); end
        do_start(5'd0, 5'd2);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL ign_pass0 got busy %b exp 0", busy_o); end
        send(16'h1234);
        checks++;
        if ({busy_o, out_valid_o, done_o, sat_o} !== 4'b0000 || out_data_o !== 16'h0002) begin
            errors++;
            $display("FAIL ign_idle got b%b v%b d%b s%b %h exp 0000 0002", busy_o, out_valid_o, done_o, sat_o, out_data_o);
        end
        do_start(5'd1, 5'd1);
        send(16'h0003);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'h0003) begin
            errors++; $display("FAIL ign_after got v%b %h exp v1 0003", out_valid_o, out_data_o);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL ign_after_done got %b exp 1", done_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_ignored();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
